// File: rtl/regfile_wb_sb.sv
// 32x32 writeback register file with a pending-write scoreboard for RAW hazard detection in ID.
// Optional write-through bypass of the writeback port is enabled with `define RF_BYPASS_EN.
module regfile_wb_sb #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int DW   = 32
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    input  logic          wwreg,
    input  logic [AW-1:0] wn,
    input  logic [DW-1:0] d,
    input  logic          iss,
    input  logic [AW-1:0] dn,
    output logic          busy_a,
    output logic          busy_b,
    output logic [AW:0]   npend
);

    logic [DW-1:0]   regs [NREG];
    logic [NREG-1:0] busy;
    logic [NREG-1:0] busy_next;
    logic            wr_en;
    logic            set_en;
    logic            inc;
    logic            dec;

    assign wr_en  = wwreg && (wn != '0);
    assign set_en = iss && (dn != '0);

    // Clear from writeback first, then set from issue, so a newer producer wins on collision.
    always_comb begin
        busy_next = busy;
        if (wr_en)
            busy_next[wn] = 1'b0;
        if (set_en)
            busy_next[dn] = 1'b1;
        busy_next[0] = 1'b0;
    end

    // npend tracks the popcount of busy incrementally; a same-register collision nets to 0.
    assign inc = set_en && !busy[dn];
    assign dec = wr_en && busy[wn] && !(set_en && (dn == wn));

    always_ff @(posedge clk) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= '0;
            busy  <= '0;
            npend <= '0;
        end else begin
            if (wr_en)
                regs[wn] <= d;
            busy  <= busy_next;
            npend <= npend + {{AW{1'b0}}, inc} - {{AW{1'b0}}, dec};
        end
    end

`ifdef RF_BYPASS_EN
    always_comb begin
        qa     = (rna == '0) ? '0 : regs[rna];
        qb     = (rnb == '0) ? '0 : regs[rnb];
        busy_a = busy[rna];
        busy_b = busy[rnb];
        if (wr_en && (rna == wn)) begin
            qa     = d;
            busy_a = 1'b0;
        end
        if (wr_en && (rnb == wn)) begin
            qb     = d;
            busy_b = 1'b0;
        end
    end
`else
    always_comb begin
        qa     = (rna == '0) ? '0 : regs[rna];
        qb     = (rnb == '0) ? '0 : regs[rnb];
        busy_a = busy[rna];
        busy_b = busy[rnb];
    end
`endif

endmodule
